if_rx_dispatch: RTL and testbench

- Consumes the 32-bit word stream from the async-FIFO read side (rd_req/rd_valid/rd_data/rd_done) after a transfer has been configured.
- Packs ACT/FLGACT/WEI/FLGWEI words into PACK-wide beats and presents them with a type code and write address to the on-chip buffers.
- Captures CFG words into a configuration register bank.
- Sits directly downstream of the SPI async-FIFO reader in the clk_chip domain.

---
 rtl/if_rx_dispatch.sv | 192 +++++++++++++++++++
 tb/tb_if_rx_dispatch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_rx_dispatch.sv
// if_rx_dispatch
// Takes the word stream from the SPI async-FIFO reader (clk_chip domain) once
// a transfer has been started, and dispatches it by transfer type:
//   - data transfers (ACT/FLGACT/WEI/FLGWEI and any unknown code) are packed
//     PACK words per beat and offered to the on-chip buffers with a beat
//     address and the transfer code;
//   - CFG transfers are captured word by word into cfg_data.
// Ports:
//   clk_chip, reset_chip       clock, asynchronous active-high reset
//   start, code                transfer start pulse and its type code
//   rd_req/rd_valid/rd_data    request/response handshake with the reader
//   rd_done                    end of transfer from the reader
//   out_valid/dst_ready        beat handshake; out_code/out_addr/out_data beat
//   cfg_data, cfg_valid        captured configuration words and their strobe
//   done, busy, err, word_cnt  status: end pulse, activity, sticky error, count
module if_rx_dispatch #(
  parameter int         SPI_WIDTH   = 32,
  parameter int         PACK        = 4,
  parameter int         ADDR_WIDTH  = 12,
  parameter int         CFG_WORDS   = 2,
  parameter int         RX_WIDTH    = 20,
  parameter logic [3:0] CODE_CFG    = 4'd0,
  parameter logic [3:0] CODE_ACT    = 4'd1,
  parameter logic [3:0] CODE_FLGACT = 4'd2,
  parameter logic [3:0] CODE_WEI    = 4'd3,
  parameter logic [3:0] CODE_FLGWEI = 4'd4
) (
  input  logic                          clk_chip,
  input  logic                          reset_chip,
  input  logic                          start,
  input  logic [3:0]                    code,
  output logic                          rd_req,
  input  logic                          rd_valid,
  input  logic [SPI_WIDTH-1:0]          rd_data,
  input  logic                          rd_done,
  output logic                          out_valid,
  input  logic                          dst_ready,
  output logic [3:0]                    out_code,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [SPI_WIDTH*PACK-1:0]     out_data,
  output logic [SPI_WIDTH*CFG_WORDS-1:0] cfg_data,
  output logic                          cfg_valid,
  output logic                          done,
  output logic                          busy,
  output logic                          err,
  output logic [RX_WIDTH-1:0]           word_cnt
);

  localparam int PW  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CIW = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;

  state_t                                state, state_nx;
  logic [PACK-1:0][SPI_WIDTH-1:0]        pack_q;
  logic [CFG_WORDS-1:0][SPI_WIDTH-1:0]   cfg_q;
  logic [PW-1:0]                         pack_cnt;
  logic [ADDR_WIDTH-1:0]                 addr;
  logic [SPI_WIDTH-1:0]                  skid;
  logic                                  skid_full;
  logic                                  is_cfg;
  logic                                  accept;
  logic                                  rx;
  logic                                  rx_data;
  logic [CIW-1:0]                        cfg_idx;

  // Only CFG is special; every other code, known or not, is packed as data.
  function automatic logic code_is_cfg(input logic [3:0] c);
    case (c)
      CODE_CFG:                                     return 1'b1;
      CODE_ACT, CODE_FLGACT, CODE_WEI, CODE_FLGWEI: return 1'b0;
      default:                                      return 1'b0;
    endcase
  endfunction

  assign is_cfg   = code_is_cfg(out_code);
  assign accept   = out_valid && dst_ready;
  assign rx       = (state == RECV) && rd_valid;
  assign rx_data  = rx && !is_cfg;
  assign cfg_idx  = word_cnt[CIW-1:0];
  assign out_data = pack_q;
  assign cfg_data = cfg_q;
  assign out_addr = addr;

  always_ff @(posedge clk_chip or posedge reset_chip) begin
    if (reset_chip) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rd_req    = 1'b0;
    done      = 1'b0;
    cfg_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nx = RECV;
      RECV: begin
        // one request in flight at most, so the single skid entry suffices
        rd_req = !out_valid && !skid_full;
        if (rd_done) state_nx = FLUSH;
      end
      FLUSH: begin
        // leave once every beat, including a partial one, has been taken
        if (!out_valid && !skid_full && (pack_cnt == '0 || is_cfg))
          state_nx = DONE;
      end
      DONE: begin
        done      = 1'b1;
        cfg_valid = is_cfg;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_chip or posedge reset_chip) begin
    if (reset_chip) begin
      out_code  <= '0;
      word_cnt  <= '0;
      pack_cnt  <= '0;
      addr      <= '0;
      pack_q    <= '0;
      cfg_q     <= '0;
      skid      <= '0;
      skid_full <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (rd_valid) err <= 1'b1;
        if (start) begin
          out_code  <= code;
          word_cnt  <= '0;
          pack_cnt  <= '0;
          addr      <= '0;
          pack_q    <= '0;
          skid      <= '0;
          skid_full <= 1'b0;
        end
      end else if (start) begin
        err <= 1'b1;
      end

      if (rx) word_cnt <= word_cnt + 1'b1;

      if (rx && is_cfg) begin
        if (word_cnt < RX_WIDTH'(CFG_WORDS)) cfg_q[cfg_idx] <= rd_data;
        else                                 err <= 1'b1;
      end

      if (out_valid) begin
        if (accept) begin
          // beat taken: restart packing from slot 0, seeded by the skid
          // entry or by a word landing in this very cycle
          out_valid <= 1'b0;
          addr      <= addr + 1'b1;
          pack_q    <= '0;
          if (skid_full) begin
            pack_q[0] <= skid;
            pack_cnt  <= PW'(1);
            skid_full <= 1'b0;
            if (rx_data) err <= 1'b1;
          end else if (rx_data) begin
            pack_q[0] <= rd_data;
            pack_cnt  <= PW'(1);
          end
        end else if (rx_data) begin
          // beat is held stable; park the in-flight word
          if (skid_full) err <= 1'b1;
          else begin
            skid      <= rd_data;
            skid_full <= 1'b1;
          end
        end
      end else if (rx_data) begin
        pack_q[pack_cnt] <= rd_data;
        if (pack_cnt == PW'(PACK - 1)) begin
          pack_cnt  <= '0;
          out_valid <= 1'b1;
        end else begin
          pack_cnt <= pack_cnt + 1'b1;
        end
      end else if (state == FLUSH && !skid_full && pack_cnt != '0 && !is_cfg) begin
        // partial last beat; slots past pack_cnt are still zero
        out_valid <= 1'b1;
        pack_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_rx_dispatch.sv
module tb_if_rx_dispatch;

  localparam int W  = 32;
  localparam int P  = 4;
  localparam int AW = 12;
  localparam int CW = 2;
  localparam int RW = 20;

  logic              clk_chip = 1'b0;
  logic              reset_chip;
  logic              start;
  logic [3:0]        code;
  logic              rd_req;
  logic              rd_valid;
  logic [W-1:0]      rd_data;
  logic              rd_done;
  logic              out_valid;
  logic              dst_ready;
  logic [3:0]        out_code;
  logic [AW-1:0]     out_addr;
  logic [W*P-1:0]    out_data;
  logic [W*CW-1:0]   cfg_data;
  logic              cfg_valid;
  logic              done;
  logic              busy;
  logic              err;
  logic [RW-1:0]     word_cnt;

  always #5 clk_chip = ~clk_chip;

  if_rx_dispatch dut (
    .clk_chip  (clk_chip),
    .reset_chip(reset_chip),
    .start     (start),
    .code      (code),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_done   (rd_done),
    .out_valid (out_valid),
    .dst_ready (dst_ready),
    .out_code  (out_code),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .word_cnt  (word_cnt)
  );

  typedef struct {
    logic [AW-1:0]  a;
    logic [W*P-1:0] d;
  } beat_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // reader model and observation state
  logic [W-1:0] words[$];
  beat_t        got[$];
  int           issued;
  bit           req_prev;
  bit           done_sent;
  bit           done_same;
  int           ready_mode;
  int           hold_left;
  int           ready_pct;
  int           done_cnt;
  int           cfgv_cnt;
  bit           ov_seen;
  bit           prev_stall;
  logic [W*P-1:0] prev_data;
  logic [AW-1:0]  prev_addr;

  task automatic chk(input string tag, input logic [W*P-1:0] obs, input logic [W*P-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    start      = 1'b0;
    code       = 4'd0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    rd_done    = 1'b0;
    dst_ready  = 1'b1;
    reset_chip = 1'b1;
    @(posedge clk_chip);
    #1;
    reset_chip = 1'b0;
  endtask

  // One clock: drive inputs for the coming edge, then observe what that edge will do.
  task automatic point(input bit st, input logic [3:0] xcode);
    @(posedge clk_chip);
    #1;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
      chk("hold_addr", out_addr, prev_addr);
      chk("stall_rd_req", rd_req, 0);
    end
    start    = st;
    code     = xcode;
    rd_valid = 1'b0;
    rd_done  = 1'b0;
    if (req_prev && issued < words.size()) begin
      rd_valid = 1'b1;
      rd_data  = words[issued];
      issued++;
    end
    if (!done_sent && issued == words.size() && (!rd_valid || done_same)) begin
      rd_done   = 1'b1;
      done_sent = 1'b1;
    end
    case (ready_mode)
      0: dst_ready = 1'b1;
      1: begin
        if (out_valid && hold_left > 0) begin
          dst_ready = 1'b0;
          hold_left--;
        end else dst_ready = 1'b1;
      end
      default: dst_ready = ($urandom_range(0, 99) < ready_pct);
    endcase
    if (out_valid) ov_seen = 1'b1;
    if (out_valid && dst_ready) got.push_back('{a: out_addr, d: out_data});
    if (done) done_cnt++;
    if (cfg_valid) cfgv_cnt++;
    prev_stall = out_valid && !dst_ready;
    prev_data  = out_data;
    prev_addr  = out_addr;
    req_prev   = rd_req;
  endtask

  task automatic run_xfer(input logic [3:0] xcode, input int mode, input int hold, input int pct,
                          input bit dsame, input int mid_start, input int abort_after,
                          input bit exp_err);
    int   idx;
    bit   fin;
    bit   cfg;
    int   n;
    int   nb;
    logic [W*P-1:0]  d;
    logic [W*CW-1:0] c;
    issued = 0; req_prev = 0; done_sent = 0; done_cnt = 0; cfgv_cnt = 0;
    ov_seen = 0; prev_stall = 0; got.delete();
    ready_mode = mode; hold_left = hold; ready_pct = pct; done_same = dsame;
    n   = words.size();
    cfg = (xcode == 4'd0);
    idx = 0;
    fin = 0;
    while (!fin && idx < 3000) begin
      point(idx == 0 || idx == mid_start, (idx == 0) ? xcode : 4'($urandom_range(0, 15)));
      if (idx == 1) chk("busy_recv", busy, 1);
      if (abort_after > 0 && issued == abort_after) begin
        @(posedge clk_chip);
        #1;
        rd_valid = 1'b0;
        chk("pre_abort_word_cnt", word_cnt, abort_after);
        chk("pre_abort_busy", busy, 1);
        #2;
        reset_chip = 1'b1;
        #1;
        chk("abort_out_data", out_data, 0);
        chk("abort_cfg_data", cfg_data, 0);
        chk("abort_ctrl", {rd_req, out_valid, out_code, out_addr, cfg_valid, done, busy, err, word_cnt}, 0);
        @(posedge clk_chip);
        #1;
        reset_chip = 1'b0;
        return;
      end
      if (done_cnt > 0) fin = 1;
      idx++;
    end
    if (!fin) chk("done_timeout", done_cnt, 1);
    point(1'b0, xcode);
    chk("done_once", done_cnt, 1);
    chk("cfg_valid_cnt", cfgv_cnt, cfg ? 1 : 0);
    chk("idle_after", busy, 0);
    chk("word_cnt", word_cnt, n);
    chk("err", err, exp_err);
    chk("out_code", out_code, xcode);
    if (cfg) begin
      c = '0;
      for (int i = 0; i < CW && i < n; i++) c[i*W +: W] = words[i];
      chk("cfg_data", cfg_data, c);
      chk("cfg_no_valid", ov_seen, 0);
    end else begin
      nb = (n + P - 1) / P;
      chk("beat_count", got.size(), nb);
      for (int b = 0; b < nb && b < got.size(); b++) begin
        d = '0;
        for (int j = 0; j < P; j++)
          if (b * P + j < n) d[j*W +: W] = words[b * P + j];
        chk("beat_addr", got[b].a, b);
        chk("beat_data", got[b].d, d);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] cds[6];
    logic [3:0] xc;
    cds[0] = 4'd0; cds[1] = 4'd1; cds[2] = 4'd2;
    cds[3] = 4'd3; cds[4] = 4'd4; cds[5] = 4'd9;

    // reset state
    do_reset();
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_data", cfg_data, 0);
    chk("rst_ctrl", {rd_req, out_valid, out_code, out_addr, cfg_valid, done, busy, err, word_cnt}, 0);

    // ACT, 8 words, always ready
    words.delete();
    for (int i = 1; i <= 8; i++) words.push_back(i);
    run_xfer(4'd1, 0, 0, 100, 1'b0, -1, 0, 1'b0);

    // ACT, first beat stalled for 5 cycles
    do_reset();
    run_xfer(4'd1, 1, 5, 100, 1'b0, -1, 0, 1'b0);

    // WEI, 5 words: one full beat plus a padded partial
    do_reset();
    words.delete();
    for (int i = 10; i <= 14; i++) words.push_back(i);
    run_xfer(4'd3, 0, 0, 100, 1'b0, -1, 0, 1'b0);

    // CFG with one word too many
    do_reset();
    words.delete();
    words.push_back(32'h11); words.push_back(32'h22); words.push_back(32'h33);
    run_xfer(4'd0, 0, 0, 100, 1'b0, -1, 0, 1'b1);

    // start pulsed mid-transfer
    do_reset();
    words.delete();
    for (int i = 1; i <= 8; i++) words.push_back(32'h100 + i);
    run_xfer(4'd1, 0, 0, 100, 1'b0, 5, 0, 1'b1);

    // reset after 3 of 8 words, then a fresh transfer
    do_reset();
    words.delete();
    for (int i = 1; i <= 8; i++) words.push_back(32'hA0 + i);
    run_xfer(4'd1, 0, 0, 100, 1'b0, -1, 3, 1'b0);
    words.delete();
    for (int i = 1; i <= 8; i++) words.push_back(32'hB0 + i);
    run_xfer(4'd1, 0, 0, 100, 1'b0, -1, 0, 1'b0);

    // rd_valid while idle
    do_reset();
    rd_valid = 1'b1;
    rd_data  = 32'hDEAD;
    @(posedge clk_chip);
    #1;
    rd_valid = 1'b0;
    chk("idle_rd_valid_err", err, 1);
    chk("idle_rd_valid_cnt", word_cnt, 0);

    // randomized transfers
    for (int t = 0; t < 25; t++) begin
      do_reset();
      xc = cds[$urandom_range(0, 5)];
      n  = (xc == 4'd0) ? $urandom_range(1, 4) : $urandom_range(1, 14);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_xfer(xc, 2, 0, $urandom_range(20, 100), 1'($urandom_range(0, 1)), -1, 0,
               (xc == 4'd0) && (n > CW));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
